m3_speed_ramp_gen: RTL and testbench

Parametrised successor to the motor speed increment/decrement calculator. It produces the commanded round period `dstRoundLenO` for the 3-phase commutation generator from INC/DEC requests sampled on round boundaries. It adds what the earlier block lacked:
- controlled direction reversal (decelerate, flip, resume);
- a force-stop ramp with hold;
- configurable step size and hysteresis.

It sits between the panel/command decode and the commutation timer.

---
 rtl/m3_speed_ramp_gen_pkg.sv | 18 +
 rtl/m3_speed_ramp_gen_if.sv | 37 +++
 rtl/m3_speed_ramp_gen_ramp_step.sv | 50 +++++
 rtl/m3_speed_ramp_gen.sv | 150 +++++++++++++++
 tb/tb_m3_speed_ramp_gen.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/m3_speed_ramp_gen_pkg.sv
// Shared types for the motor speed ramp generator: FSM state encoding,
// ramp (hysteresis) mode and the width of the exported state field.
package m3_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_REVERSE = 2'd2,
        ST_STOP    = 2'd3
    } m3State_t;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_FAST = 2'd1,
        MODE_SLOW = 2'd2
    } rampMode_t;
endpackage

// File: rtl/m3_speed_ramp_gen_if.sv
// Command/status bundle between command decode, the speed ramp generator
// and the commutation timer. Target ports exist only with M3_SPEED_TARGET_EN.
interface m3_speed_ramp_gen_if
    import m3_pkg::*;
#(
    parameter int LEN_W = 32
);
    logic               workingI;
    logic               nextRound_1I;
    logic               m3speedINCi;
    logic               m3speedDECi;
    logic               m3invRotateI;
    logic               m3forceStopI;
    logic [LEN_W-1:0]   dstRoundLenO;
    logic               dirO;
    logic [STATE_W-1:0] stateO;
    logic               atMinO;
    logic               atMaxO;
`ifdef M3_SPEED_TARGET_EN
    logic [LEN_W-1:0]   targetLenI;
    logic               targetValidI;

    modport master (output workingI, nextRound_1I, m3speedINCi, m3speedDECi,
                    m3invRotateI, m3forceStopI, targetLenI, targetValidI,
                    input dstRoundLenO, dirO, stateO, atMinO, atMaxO);
    modport slave  (input workingI, nextRound_1I, m3speedINCi, m3speedDECi,
                    m3invRotateI, m3forceStopI, targetLenI, targetValidI,
                    output dstRoundLenO, dirO, stateO, atMinO, atMaxO);
`else
    modport master (output workingI, nextRound_1I, m3speedINCi, m3speedDECi,
                    m3invRotateI, m3forceStopI,
                    input dstRoundLenO, dirO, stateO, atMinO, atMaxO);
    modport slave  (input workingI, nextRound_1I, m3speedINCi, m3speedDECi,
                    m3invRotateI, m3forceStopI,
                    output dstRoundLenO, dirO, stateO, atMinO, atMaxO);
`endif
endinterface

// File: rtl/m3_speed_ramp_gen_ramp_step.sv
// One ramp step: current period plus direction (and optional target) to the
// next clamped period. Arithmetic is one bit wider than the period so neither
// the add nor the subtract can wrap.
module m3_ramp_step #(
    parameter int LEN_W      = 32,
    parameter int STEP_SHIFT = 4,
    parameter int PERIOD_MIN = 40,
    parameter int PERIOD_MAX = 4000000
) (
    input  logic [LEN_W-1:0] lenI,
    input  logic             slowerI,
    input  logic             useTgtI,
    input  logic [LEN_W-1:0] tgtI,
    output logic [LEN_W-1:0] nextLenO,
    output logic [LEN_W-1:0] tgtLenO
);
    localparam logic [LEN_W:0] MIN_W = (LEN_W+1)'(PERIOD_MIN);
    localparam logic [LEN_W:0] MAX_W = (LEN_W+1)'(PERIOD_MAX);

    logic [LEN_W:0] tgtW;
    logic [LEN_W:0] lenW;
    logic [LEN_W:0] stepW;
    logic [LEN_W:0] fastW;
    logic [LEN_W:0] slowW;
    logic [LEN_W:0] nextW;

    // Target clamped into the legal period window; kept separate from the
    // step logic so the parent can use it to pick a direction.
    assign tgtW    = ({1'b0, tgtI} < MIN_W) ? MIN_W :
                     ({1'b0, tgtI} > MAX_W) ? MAX_W : {1'b0, tgtI};
    assign tgtLenO = tgtW[LEN_W-1:0];

    // Proportional step with a floor of 1, clamped to the period window and
    // optionally stopped exactly at the target instead of overshooting it.
    always_comb begin
        lenW  = {1'b0, lenI};
        stepW = lenW >> STEP_SHIFT;
        if (stepW == '0) stepW = (LEN_W+1)'(1);
        if (lenW <= stepW + MIN_W) fastW = MIN_W;
        else                       fastW = lenW - stepW;
        slowW = lenW + stepW;
        if (slowW > MAX_W) slowW = MAX_W;
        nextW = slowerI ? slowW : fastW;
        if (useTgtI) begin
            if (slowerI && (nextW > tgtW))  nextW = tgtW;
            if (!slowerI && (nextW < tgtW)) nextW = tgtW;
        end
        nextLenO = nextW[LEN_W-1:0];
    end
endmodule

// File: rtl/m3_speed_ramp_gen.sv
// Motor speed ramp generator: turns INC/DEC requests sampled on round
// boundaries into the commanded round period, with hysteresis, controlled
// direction reversal and a force-stop ramp.
// Optional feature macro: M3_SPEED_TARGET_EN (ramp toward targetLenI).
module m3_speed_ramp_gen
    import m3_pkg::*;
#(
    parameter int LEN_W           = 32,
    parameter int PERIOD_MAX      = 4000000,
    parameter int PERIOD_MIN      = 40,
    parameter int STEP_SHIFT      = 4,
    parameter int ROUNDS_PER_STEP = 4
) (
    input  logic               clkI,
    input  logic               nRstI,
    m3_speed_ramp_gen_if.slave bus
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PERIOD_MAX);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(PERIOD_MIN);
    localparam logic [3:0]       RPS     = 4'(ROUNDS_PER_STEP);

    m3State_t         state, nState;
    rampMode_t        modeQ, nMode, reqMode;
    logic [LEN_W-1:0] lenQ, nLen, stepLen, tgtLen, tgtIn;
    logic [3:0]       cntQ, nCnt, cntInc;
    logic             dirQ, nDir, atMinQ, atMaxQ;
    logic             tgtValid, tgtActive, stepSlower, useTgt;

`ifdef M3_SPEED_TARGET_EN
    assign tgtValid = bus.targetValidI;
    assign tgtIn    = bus.targetLenI;
`else
    assign tgtValid = 1'b0;
    assign tgtIn    = '0;
`endif

    m3_ramp_step #(
        .LEN_W(LEN_W), .STEP_SHIFT(STEP_SHIFT),
        .PERIOD_MIN(PERIOD_MIN), .PERIOD_MAX(PERIOD_MAX)
    ) uStep (
        .lenI(lenQ), .slowerI(stepSlower), .useTgtI(useTgt),
        .tgtI(tgtIn), .nextLenO(stepLen), .tgtLenO(tgtLen)
    );

    // Requested ramp mode: manual INC/DEC first, then the target (if any).
    // Outside RUN every step is a slower step.
    always_comb begin
        tgtActive  = tgtValid && !bus.m3speedINCi && !bus.m3speedDECi && (tgtLen != lenQ);
        if (bus.m3speedINCi)      reqMode = MODE_FAST;
        else if (bus.m3speedDECi) reqMode = MODE_SLOW;
        else if (tgtActive)       reqMode = (tgtLen > lenQ) ? MODE_SLOW : MODE_FAST;
        else                      reqMode = MODE_NONE;
        stepSlower = (state != ST_RUN) || (reqMode == MODE_SLOW);
        useTgt     = tgtActive && (state == ST_RUN);
    end

    // Next-state and next-register logic; period changes only on round pulses.
    always_comb begin
        nState = state;
        nLen   = lenQ;
        nDir   = dirQ;
        nCnt   = cntQ;
        nMode  = modeQ;
        cntInc = (modeQ != reqMode) ? 4'd1 : cntQ + 4'd1;
        if (!bus.workingI) begin
            nState = ST_IDLE;
            nLen   = LEN_MAX;
            nDir   = bus.m3invRotateI;
            nCnt   = '0;
            nMode  = MODE_NONE;
        end else begin
            unique case (state)
                ST_IDLE: nState = ST_RUN;
                ST_RUN, ST_REVERSE: begin
                    if (bus.m3forceStopI) begin
                        nState = ST_STOP;
                        nCnt   = '0;
                        nMode  = MODE_NONE;
                    end else if (bus.m3invRotateI != dirQ) begin
                        if (state == ST_RUN) begin
                            nState = ST_REVERSE;
                            nCnt   = '0;
                            nMode  = MODE_NONE;
                        end else if (bus.nextRound_1I) begin
                            nLen = stepLen;
                            // Flip only once the motor is at its slowest.
                            if (stepLen == LEN_MAX) begin
                                nDir   = bus.m3invRotateI;
                                nState = ST_RUN;
                            end
                        end
                    end else if (state == ST_REVERSE) begin
                        nState = ST_RUN;
                    end else if (bus.nextRound_1I) begin
                        if (reqMode == MODE_NONE) begin
                            nCnt  = '0;
                            nMode = MODE_NONE;
                        end else begin
                            nMode = reqMode;
                            if (cntInc >= RPS) begin
                                nLen = stepLen;
                                nCnt = '0;
                            end else begin
                                nCnt = cntInc;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (!bus.m3forceStopI) begin
                        nState = ST_RUN;
                        nCnt   = '0;
                        nMode  = MODE_NONE;
                    end else if (lenQ == LEN_MAX) begin
                        nDir = bus.m3invRotateI;
                    end else if (bus.nextRound_1I) begin
                        nLen = stepLen;
                    end
                end
            endcase
        end
    end

    // State and output registers; limit flags are registered alongside the period.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state  <= ST_IDLE;
            lenQ   <= LEN_MAX;
            dirQ   <= 1'b0;
            cntQ   <= '0;
            modeQ  <= MODE_NONE;
            atMinQ <= 1'b0;
            atMaxQ <= 1'b1;
        end else begin
            state  <= nState;
            lenQ   <= nLen;
            dirQ   <= nDir;
            cntQ   <= nCnt;
            modeQ  <= nMode;
            atMinQ <= (nLen == LEN_MIN);
            atMaxQ <= (nLen == LEN_MAX);
        end
    end

    assign bus.dstRoundLenO = lenQ;
    assign bus.dirO         = dirQ;
    assign bus.stateO       = state;
    assign bus.atMinO       = atMinQ;
    assign bus.atMaxO       = atMaxQ;
endmodule

// File: tb/tb_m3_speed_ramp_gen.sv
// Directed bench for m3_speed_ramp_gen with PERIOD_MAX=300, PERIOD_MIN=40,
// STEP_SHIFT=4, ROUNDS_PER_STEP=4. Expected values are hand-computed.
module tb_m3_speed_ramp_gen;
    logic clkI = 1'b0;
    logic nRstI = 1'b0;
    int   nAsserts = 0;
    int   nFails = 0;

    m3_speed_ramp_gen_if #(.LEN_W(32)) bus ();

    m3_speed_ramp_gen #(
        .LEN_W(32), .PERIOD_MAX(300), .PERIOD_MIN(40),
        .STEP_SHIFT(4), .ROUNDS_PER_STEP(4)
    ) dut (
        .clkI(clkI), .nRstI(nRstI), .bus(bus)
    );

    always #5 clkI = ~clkI;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles, leaving time just after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clkI);
        #1;
    endtask

    // One-cycle round pulse; result is visible on return.
    task automatic pulse();
        bus.nextRound_1I = 1'b1;
        @(posedge clkI);
        #1;
        bus.nextRound_1I = 1'b0;
    endtask

    initial begin
        bus.workingI     = 1'b0;
        bus.nextRound_1I = 1'b0;
        bus.m3speedINCi  = 1'b0;
        bus.m3speedDECi  = 1'b0;
        bus.m3invRotateI = 1'b0;
        bus.m3forceStopI = 1'b0;
`ifdef M3_SPEED_TARGET_EN
        bus.targetLenI   = '0;
        bus.targetValidI = 1'b0;
`endif
        tick(2);
        chk("rst_len", bus.dstRoundLenO, 300);
        chk("rst_dir", bus.dirO, 0);
        chk("rst_state", bus.stateO, 0);
        chk("rst_atMax", bus.atMaxO, 1);
        chk("rst_atMin", bus.atMinO, 0);
        nRstI = 1'b1;
        tick(1);

        // IDLE -> RUN, INC held for 8 pulses
        bus.workingI = 1'b1;
        tick(1);
        chk("run_state", bus.stateO, 1);
        bus.m3speedINCi = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            pulse();
            chk("inc_hold", bus.dstRoundLenO, 300);
        end
        pulse();
        chk("inc_p4", bus.dstRoundLenO, 282);
        repeat (3) pulse();
        chk("inc_p7", bus.dstRoundLenO, 282);
        pulse();
        chk("inc_p8", bus.dstRoundLenO, 265);
        bus.m3speedINCi = 1'b0;

        // Reversal from 265
        bus.m3invRotateI = 1'b1;
        tick(1);
        chk("rev_state", bus.stateO, 2);
        pulse();
        chk("rev_p1", bus.dstRoundLenO, 281);
        chk("rev_dir_held", bus.dirO, 0);
        pulse();
        chk("rev_p2", bus.dstRoundLenO, 298);
        pulse();
        chk("rev_p3", bus.dstRoundLenO, 300);
        chk("rev_dir", bus.dirO, 1);
        chk("rev_back_run", bus.stateO, 1);

        // Force stop from 265: ramp to 300, hold, dir tracks request
        bus.m3speedINCi = 1'b1;
        repeat (8) pulse();
        chk("pre_stop_len", bus.dstRoundLenO, 265);
        bus.m3speedINCi = 1'b0;
        bus.m3forceStopI = 1'b1;
        tick(1);
        chk("stop_state", bus.stateO, 3);
        pulse();
        chk("stop_p1", bus.dstRoundLenO, 281);
        pulse();
        chk("stop_p2", bus.dstRoundLenO, 298);
        pulse();
        chk("stop_p3", bus.dstRoundLenO, 300);
        pulse();
        chk("stop_hold", bus.dstRoundLenO, 300);
        bus.m3invRotateI = 1'b0;
        tick(1);
        chk("stop_dir0", bus.dirO, 0);
        bus.m3invRotateI = 1'b1;
        tick(1);
        chk("stop_dir1", bus.dirO, 1);
        bus.m3forceStopI = 1'b0;
        tick(1);
        chk("unstop_state", bus.stateO, 1);

        // workingI low -> IDLE
        bus.workingI = 1'b0;
        tick(1);
        chk("idle_state", bus.stateO, 0);
        chk("idle_len", bus.dstRoundLenO, 300);
        bus.workingI = 1'b1;
        tick(1);

        // Counter restart on INC->DEC, then clamp at max
        bus.m3speedINCi = 1'b1;
        repeat (4) pulse();
        chk("hyst_282", bus.dstRoundLenO, 282);
        repeat (3) pulse();
        bus.m3speedINCi = 1'b0;
        bus.m3speedDECi = 1'b1;
        repeat (3) pulse();
        chk("dec_p3", bus.dstRoundLenO, 282);
        pulse();
        chk("dec_p4", bus.dstRoundLenO, 299);
        repeat (4) pulse();
        chk("dec_clamp", bus.dstRoundLenO, 300);
        chk("dec_atMax", bus.atMaxO, 1);
        bus.m3speedDECi = 1'b0;

        // forceStop falls mid-ramp: RUN at current period
        bus.m3speedINCi = 1'b1;
        repeat (8) pulse();
        bus.m3speedINCi = 1'b0;
        bus.m3forceStopI = 1'b1;
        tick(1);
        pulse();
        chk("mid_stop_len", bus.dstRoundLenO, 281);
        bus.m3forceStopI = 1'b0;
        tick(1);
        chk("mid_stop_run", bus.stateO, 1);
        chk("mid_stop_keep", bus.dstRoundLenO, 281);

        // workingI falls mid-ramp
        bus.m3forceStopI = 1'b1;
        tick(1);
        pulse();
        chk("mid_work_len", bus.dstRoundLenO, 298);
        bus.workingI = 1'b0;
        tick(1);
        chk("mid_work_idle", bus.stateO, 0);
        chk("mid_work_max", bus.dstRoundLenO, 300);
        bus.m3forceStopI = 1'b0;
        bus.workingI = 1'b1;
        tick(1);

        // Ramp down to the minimum (bounded), then 40 -> 42 -> 40
        bus.m3speedINCi = 1'b1;
        for (int i = 0; i < 200 && !bus.atMinO; i++) pulse();
        chk("min_reached", bus.atMinO, 1);
        chk("min_len", bus.dstRoundLenO, 40);
        bus.m3speedINCi = 1'b0;
        bus.m3speedDECi = 1'b1;
        repeat (4) pulse();
        chk("min_up_42", bus.dstRoundLenO, 42);
        chk("min_up_atMin", bus.atMinO, 0);
        bus.m3speedDECi = 1'b0;
        bus.m3speedINCi = 1'b1;
        repeat (4) pulse();
        chk("min_42_to_40", bus.dstRoundLenO, 40);
        chk("min_atMin", bus.atMinO, 1);
        repeat (4) pulse();
        chk("min_stay", bus.dstRoundLenO, 40);
        bus.m3speedINCi = 1'b0;

`ifdef M3_SPEED_TARGET_EN
        // Target ramp from 300 to 100
        bus.workingI = 1'b0;
        tick(1);
        bus.workingI = 1'b1;
        tick(1);
        bus.targetLenI   = 32'd100;
        bus.targetValidI = 1'b1;
        repeat (3) pulse();
        chk("tgt_hyst", bus.dstRoundLenO, 300);
        pulse();
        chk("tgt_first", bus.dstRoundLenO, 282);
        for (int i = 0; i < 400 && bus.dstRoundLenO != 100; i++) pulse();
        chk("tgt_land", bus.dstRoundLenO, 100);
        repeat (8) pulse();
        chk("tgt_hold", bus.dstRoundLenO, 100);
        bus.targetValidI = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
